washer_sequencer: RTL and testbench

WASHER_SEQUENCER -- requirements
Module: washer_sequencer

---
 rtl/washer_pkg.sv | 88 ++++++++
 rtl/wsq_timer.sv | 38 +++
 rtl/washer_sequencer.sv | 153 +++++++++++++++
 tb/tb_washer_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// washer_pkg
//   Shared definitions for the washer sequencer, the DC motor block and the
//   CPU interface: FSM state encodings, one-hot motor mode codes, stage
//   indices, program codes and small decode helpers.
package washer_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // One-hot stage commands to the motor block
  localparam logic [2:0] MODE_NONE  = 3'b000;
  localparam logic [2:0] MODE_WASH  = 3'b001;
  localparam logic [2:0] MODE_RINSE = 3'b010;
  localparam logic [2:0] MODE_SPIN  = 3'b100;

  // Stage indices as reported on o_stage
  localparam logic [1:0] STAGE_WASH  = 2'd0;
  localparam logic [1:0] STAGE_RINSE = 2'd1;
  localparam logic [1:0] STAGE_SPIN  = 2'd2;
  localparam logic [1:0] STAGE_NONE  = 2'd3;

  // Program codes
  localparam logic [1:0] PROG_WASH_RINSE_SPIN = 2'b00;
  localparam logic [1:0] PROG_RINSE_SPIN      = 2'b01;
  localparam logic [1:0] PROG_SPIN_ONLY       = 2'b10;
  localparam logic [1:0] PROG_WASH_ONLY       = 2'b11;

  // Registered output bundle of the sequencer
  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] stage;
    logic       busy;
    logic       done;
    logic       err;
  } seq_out_t;

  localparam seq_out_t OUT_IDLE = '{mode: MODE_NONE, stage: STAGE_NONE,
                                    busy: 1'b0, done: 1'b0, err: 1'b0};

  // Enabled-stage mask of a program; bit index equals stage index.
  function automatic logic [2:0] prog_stages(input logic [1:0] prog);
    logic [2:0] mask;
    case (prog)
      PROG_WASH_RINSE_SPIN: mask = 3'b111;
      PROG_RINSE_SPIN:      mask = 3'b110;
      PROG_SPIN_ONLY:       mask = 3'b100;
      default:              mask = 3'b001;
    endcase
    return mask;
  endfunction

  function automatic logic [2:0] stage_mode(input logic [1:0] stage);
    logic [2:0] mode;
    case (stage)
      STAGE_WASH:  mode = MODE_WASH;
      STAGE_RINSE: mode = MODE_RINSE;
      STAGE_SPIN:  mode = MODE_SPIN;
      default:     mode = MODE_NONE;
    endcase
    return mode;
  endfunction

  function automatic logic [1:0] first_stage(input logic [2:0] mask);
    logic [1:0] s;
    if (mask[0])      s = STAGE_WASH;
    else if (mask[1]) s = STAGE_RINSE;
    else if (mask[2]) s = STAGE_SPIN;
    else              s = STAGE_NONE;
    return s;
  endfunction

  // Next enabled stage strictly after cur, or STAGE_NONE if there is none.
  function automatic logic [1:0] next_stage(input logic [2:0] mask,
                                            input logic [1:0] cur);
    logic [1:0] s;
    case (cur)
      STAGE_WASH:  s = mask[1] ? STAGE_RINSE : (mask[2] ? STAGE_SPIN : STAGE_NONE);
      STAGE_RINSE: s = mask[2] ? STAGE_SPIN : STAGE_NONE;
      default:     s = STAGE_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wsq_timer.sv
// wsq_timer
//   Loadable 16-bit saturating up-counter with an expiry compare.
//   reached is high during the cycle that completes 'limit' cycles since the
//   last load, so a state that loads on entry and exits on reached occupies
//   exactly 'limit' cycles. A limit of 0 reads as already reached.
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   load        load count with load_value (priority over en)
//   load_value  value loaded on load
//   en          count enable
//   limit       expiry threshold in cycles
//   reached     expiry flag (combinational from the count register)
module wsq_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        en,
  input  logic [15:0] limit,
  output logic        reached
);

  logic [15:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 16'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // 17-bit compare so a saturated count cannot wrap the +1
  assign reached = ({1'b0, count_reg} + 17'd1) >= {1'b0, limit};

endmodule

// File: rtl/washer_sequencer.sv
// washer_sequencer
//   Steps the DC motor block through wash -> rinse -> spin, skipping stages
//   the latched program does not enable, with an idle gap between stages and
//   a per-stage watchdog. All outputs are registered and are computed from
//   the next state, so a start sampled on an edge shows its mode right after
//   that edge.
// Ports
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_start/i_stop  start and abort requests
//   i_prog          program select (latched on start)
//   i_fin           stage-complete flag from the motor block
//   o_mode          one-hot stage command (000 = none)
//   o_stage         current stage index (3 = none)
//   o_busy          high in RUN and GAP
//   o_done          one-cycle completion pulse
//   o_err           high while the watchdog error is held
module washer_sequencer
  import washer_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [1:0] i_prog,
  input  logic       i_fin,
  output logic [2:0] o_mode,
  output logic [1:0] o_stage,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [15:0] GAP_LIMIT     = 16'(GAP_CYCLES);
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic        WDOG_ON       = (TIMEOUT_CYCLES != 0);

  logic [2:0] state_reg, state_next;
  logic [1:0] prog_reg, prog_next;
  // Stage being run, or in GAP the stage that runs next
  logic [1:0] stage_reg, stage_next;
  seq_out_t   out_reg, out_next;

  logic [2:0]  stage_mask;
  logic [1:0]  following;
  logic        timer_load;
  logic        timer_en;
  logic [15:0] timer_limit;
  logic        timer_reached;

  assign stage_mask = prog_stages(prog_reg);
  assign following  = next_stage(stage_mask, stage_reg);

  // One counter serves both the gap and the watchdog: it restarts on every
  // entry into RUN or GAP and its limit follows the current state.
  assign timer_load  = ((state_next == ST_RUN) || (state_next == ST_GAP)) &&
                       (state_next != state_reg);
  assign timer_en    = (state_reg == ST_RUN) || (state_reg == ST_GAP);
  assign timer_limit = (state_reg == ST_GAP) ? GAP_LIMIT : TIMEOUT_LIMIT;

  wsq_timer u_timer (
    .clk        (i_clk),
    .rst        (i_reset),
    .load       (timer_load),
    .load_value (16'd0),
    .en         (timer_en),
    .limit      (timer_limit),
    .reached    (timer_reached)
  );

  always_comb begin
    state_next = state_reg;
    prog_next  = prog_reg;
    stage_next = stage_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          prog_next  = i_prog;
          stage_next = first_stage(prog_stages(i_prog));
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // stop beats fin, fin beats a watchdog expiry on the same edge
        if (i_stop) begin
          state_next = ST_IDLE;
        end else if (i_fin) begin
          if (following != STAGE_NONE) begin
            stage_next = following;
            state_next = ST_GAP;
          end else begin
            state_next = ST_DONE;
          end
        end else if (WDOG_ON && timer_reached) begin
          state_next = ST_ERR;
        end
      end
      ST_GAP: begin
        // a fin still held from the previous stage stretches the gap
        if (i_stop) begin
          state_next = ST_IDLE;
        end else if (timer_reached && !i_fin) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        if (i_start || i_stop) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    out_next      = OUT_IDLE;
    out_next.busy = (state_next == ST_RUN) || (state_next == ST_GAP);
    out_next.done = (state_next == ST_DONE);
    out_next.err  = (state_next == ST_ERR);
    if (state_next == ST_RUN) begin
      out_next.mode  = stage_mode(stage_next);
      out_next.stage = stage_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      prog_reg  <= PROG_WASH_RINSE_SPIN;
      stage_reg <= STAGE_WASH;
      out_reg   <= OUT_IDLE;
    end else begin
      state_reg <= state_next;
      prog_reg  <= prog_next;
      stage_reg <= stage_next;
      out_reg   <= out_next;
    end
  end

  assign o_mode  = out_reg.mode;
  assign o_stage = out_reg.stage;
  assign o_busy  = out_reg.busy;
  assign o_done  = out_reg.done;
  assign o_err   = out_reg.err;

endmodule

// File: tb/tb_washer_sequencer.sv
// tb_washer_sequencer
//   Self-checking bench for washer_sequencer (GAP_CYCLES=4, TIMEOUT_CYCLES=50).
//   Program runs are planned as per-stage durations and fin hold lengths; the
//   expected per-cycle output trace is derived from that plan arithmetically.
module tb_washer_sequencer;

  localparam int GAP = 4;
  localparam int TO  = 50;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [1:0] prog;
  logic       fin;
  logic [2:0] mode;
  logic [1:0] stage;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  // expected output encodings: {mode, stage, busy, done, err}
  localparam logic [7:0] EXP_GAP  = {3'b000, 2'd3, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] EXP_DONE = {3'b000, 2'd3, 1'b0, 1'b1, 1'b0};
  localparam logic [7:0] EXP_IDLE = {3'b000, 2'd3, 1'b0, 1'b0, 1'b0};

  logic       q_start[$];
  logic       q_fin[$];
  logic [7:0] q_exp[$];

  washer_sequencer #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_stop  (stop),
    .i_prog  (prog),
    .i_fin   (fin),
    .o_mode  (mode),
    .o_stage (stage),
    .o_busy  (busy),
    .o_done  (done),
    .o_err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  function automatic logic [7:0] exp_run(input int s);
    logic [2:0] m;
    m = 3'b001 << s;
    return {m, 2'(s), 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic rand_bit();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic void push_cyc(input logic s, input logic f, input logic [7:0] e);
    q_start.push_back(s);
    q_fin.push_back(f);
    q_exp.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    start = 1'b0;
    fin   = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    fin   = 1'b0;
    prog  = 2'b00;
    #2;
    checks++;
    if ({mode, stage, busy, done, err} !== EXP_IDLE) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", {mode, stage, busy, done, err}, EXP_IDLE);
    end
    // start already high when reset releases: taken on the first edge
    start = 1'b1;
    prog  = 2'b10;
    @(negedge clk);
    reset = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (mode !== 3'b100 || busy !== 1'b1 || stage !== 2'd2) begin
      failures++;
      $display("FAIL first_start_after_reset got mode=%b busy=%b stage=%0d want mode=100 busy=1 stage=2",
               mode, busy, stage);
    end
    go_idle();
    $display("test_reset complete");
  endtask

  task automatic test_random_programs(input int runs);
    logic [1:0] p;
    logic [2:0] mask;
    logic [7:0] obs;
    int d, h, g, last;
    bit first;
    for (int r = 0; r < runs; r++) begin
      q_start.delete();
      q_fin.delete();
      q_exp.delete();
      // first runs are the fixed scenarios: full program with fin at 10,
      // spin-only with fin at 5, full program with fin held 8 after wash
      if (r == 0)      p = 2'b00;
      else if (r == 1) p = 2'b10;
      else if (r == 2) p = 2'b00;
      else             p = 2'($urandom_range(0, 3));
      case (p)
        2'b00:   mask = 3'b111;
        2'b01:   mask = 3'b110;
        2'b10:   mask = 3'b100;
        default: mask = 3'b001;
      endcase
      last  = mask[2] ? 2 : (mask[1] ? 1 : 0);
      first = 1'b1;
      for (int s = 0; s < 3; s++) begin
        if (mask[s]) begin
          if (r == 0)      d = 10;
          else if (r == 1) d = 5;
          else             d = $urandom_range(1, 40);
          if (r < 2)       h = 1;
          else if (r == 2) h = (s == 0) ? 8 : 1;
          else             h = $urandom_range(1, 9);
          push_cyc(first ? 1'b1 : rand_bit(), 1'b0, exp_run(s));
          first = 1'b0;
          for (int k = 1; k < d; k++) push_cyc(rand_bit(), 1'b0, exp_run(s));
          if (s == last) begin
            push_cyc(rand_bit(), 1'b1, EXP_DONE);
            push_cyc(1'b0, 1'b0, EXP_IDLE);
          end else begin
            g = (h > GAP) ? h : GAP;
            push_cyc(rand_bit(), 1'b1, EXP_GAP);
            for (int k = 1; k < g; k++) push_cyc(rand_bit(), (k < h), EXP_GAP);
          end
        end
      end
      for (int i = 0; i < q_exp.size(); i++) begin
        start = q_start[i];
        fin   = q_fin[i];
        prog  = (i == 0) ? p : 2'($urandom_range(0, 3));
        tick();
        obs = {mode, stage, busy, done, err};
        checks++;
        if (obs !== q_exp[i]) begin
          failures++;
          $display("FAIL trace run=%0d cyc=%0d prog=%b got=%b want=%b", r, i, p, obs, q_exp[i]);
        end
      end
      start = 1'b0;
      fin   = 1'b0;
      $display("run %0d prog=%b cycles=%0d", r, p, q_exp.size());
    end
  endtask

  task automatic test_timeout();
    int run_len;
    go_idle();
    prog  = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_len = 0;
    for (int k = 0; k < 200; k++) begin
      if (mode !== 3'b001) break;
      run_len++;
      tick();
    end
    checks++;
    if (run_len !== TO) begin
      failures++;
      $display("FAIL timeout_length got=%0d want=%0d", run_len, TO);
    end
    checks++;
    if (err !== 1'b1 || mode !== 3'b000 || busy !== 1'b0 || stage !== 2'd3) begin
      failures++;
      $display("FAIL timeout_err got err=%b mode=%b busy=%b stage=%0d want err=1 mode=000 busy=0 stage=3",
               err, mode, busy, stage);
    end
    tick();
    tick();
    tick();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_held got=%b want=1", err);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || mode !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_clear_no_restart got err=%b mode=%b busy=%b want err=0 mode=000 busy=0",
               err, mode, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || mode !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_err got busy=%b mode=%b want busy=0 mode=000", busy, mode);
    end
    $display("test_timeout run_len=%0d", run_len);
  endtask

  task automatic test_fin_at_expiry();
    go_idle();
    prog  = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < TO; k++) tick();
    checks++;
    if (mode !== 3'b001) begin
      failures++;
      $display("FAIL last_run_cycle got mode=%b want 001", mode);
    end
    fin = 1'b1;
    tick();
    fin = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || mode !== 3'b000) begin
      failures++;
      $display("FAIL fin_beats_expiry got done=%b err=%b mode=%b want done=1 err=0 mode=000",
               done, err, mode);
    end
    tick();
    checks++;
    if ({mode, stage, busy, done, err} !== EXP_IDLE) begin
      failures++;
      $display("FAIL idle_after_done got=%b want=%b", {mode, stage, busy, done, err}, EXP_IDLE);
    end
    $display("test_fin_at_expiry complete");
  endtask

  task automatic test_stop_fin_rinse();
    go_idle();
    // stop wins over start in IDLE
    prog  = 2'b00;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || mode !== 3'b000) begin
      failures++;
      $display("FAIL stop_over_start got busy=%b mode=%b want busy=0 mode=000", busy, mode);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    fin = 1'b1;
    tick();
    fin = 1'b0;
    for (int k = 0; k < GAP; k++) tick();
    checks++;
    if (mode !== 3'b010 || stage !== 2'd1) begin
      failures++;
      $display("FAIL rinse_entry got mode=%b stage=%0d want mode=010 stage=1", mode, stage);
    end
    tick();
    stop = 1'b1;
    fin  = 1'b1;
    tick();
    stop = 1'b0;
    fin  = 1'b0;
    checks++;
    if ({mode, stage, busy, done, err} !== EXP_IDLE) begin
      failures++;
      $display("FAIL stop_with_fin got=%b want=%b", {mode, stage, busy, done, err}, EXP_IDLE);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL no_done_after_stop got done=%b busy=%b want done=0 busy=0", done, busy);
    end
    $display("test_stop_fin_rinse complete");
  endtask

  task automatic test_reset_mid_wash();
    go_idle();
    prog  = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (mode !== 3'b001) begin
      failures++;
      $display("FAIL wash_before_reset got mode=%b want 001", mode);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({mode, stage, busy, done, err} !== EXP_IDLE) begin
      failures++;
      $display("FAIL async_reset got=%b want=%b", {mode, stage, busy, done, err}, EXP_IDLE);
    end
    #19;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({mode, stage, busy, done, err} !== EXP_IDLE) begin
        failures++;
        $display("FAIL after_reset_release cyc=%0d got=%b want=%b", k, {mode, stage, busy, done, err}, EXP_IDLE);
      end
    end
    $display("test_reset_mid_wash complete");
  endtask

  task automatic test_start_while_busy();
    go_idle();
    prog  = 2'b10;
    start = 1'b1;
    tick();
    prog  = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (mode !== 3'b100) begin
        failures++;
        $display("FAIL start_ignored cyc=%0d got mode=%b want 100", k, mode);
      end
    end
    start = 1'b0;
    fin   = 1'b1;
    tick();
    fin   = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_spin_only got done=%b want 1", done);
    end
    tick();
    checks++;
    if (mode !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_spin got mode=%b busy=%b want mode=000 busy=0", mode, busy);
    end
    $display("test_start_while_busy complete");
  endtask

  initial begin
    test_reset();
    test_random_programs(20);
    test_timeout();
    test_fin_at_expiry();
    test_stop_fin_rinse();
    test_reset_mid_wash();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
